commit_unit_v: RTL

- Scalar-unit-side receiver for vector-lane commit reports. It is the return end of the scalar-to-vector command path: the scalar unit sends a command (instr_t plus issue_no_t) to the lanes, and each lane later reports completion.
- Holds a commit_tab_v entry per outstanding vector command and collects per-lane commit flags into it.
- Retires entries strictly in issue order. Each retirement emits one issue_no pulse to the hazard unit so that the matching hazard-table entry is cleared.

---
 rtl/commit_unit_v_pkg.sv | 26 ++
 rtl/commit_unit_v_match.sv | 20 ++
 rtl/commit_unit_v.sv | 113 +++++++++++
 3 files changed

// File: rtl/commit_unit_v_pkg.sv
// Shared TPU types: commit-table entry format and lane/issue-number types
// used by the scalar-side commit receiver.
package pkg_tpu;

  localparam int NUM_LANE           = 4;
  localparam int NUM_ENTRY_HAZARD   = 8;
  localparam int WIDTH_ENTRY_HAZARD = $clog2(NUM_ENTRY_HAZARD);

  typedef logic [WIDTH_ENTRY_HAZARD-1:0] issue_no_t;
  typedef logic [NUM_LANE-1:0]           commit_lane_t;
  typedef issue_no_t [NUM_LANE-1:0]      lane_issue_no_t;

  typedef struct packed {
    logic         v;
    logic         commit;
    issue_no_t    issue_no;
    commit_lane_t en_lane;
    commit_lane_t en_commit;
  } commit_tab_v;

  // An entry is done once every lane it was sent to has reported back.
  function automatic logic is_complete(commit_tab_v e);
    return e.v && ((e.en_commit & e.en_lane) == e.en_lane);
  endfunction

endpackage

// File: rtl/commit_unit_v_match.sv
// Per-lane lookup: one-hot hit vector of the valid table entry carrying issue_no.
module commit_match
  import pkg_tpu::*;
#(
  parameter int NUM_ENTRY = NUM_ENTRY_HAZARD
) (
  input  commit_tab_v [NUM_ENTRY-1:0] tab,
  input  logic                        valid,
  input  issue_no_t                   issue_no,
  output logic [NUM_ENTRY-1:0]        hit
);

  always_comb begin
    hit = '0;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      hit[e] = valid && tab[e].v && (tab[e].issue_no == issue_no);
    end
  end

endmodule

// File: rtl/commit_unit_v.sv
// Vector-lane commit receiver: collects per-lane commit flags per outstanding
// command and retires commands strictly in issue order, one pulse per retirement.
module commit_unit_v
  import pkg_tpu::*;
#(
  parameter int NUM_ENTRY   = NUM_ENTRY_HAZARD,
  parameter int WIDTH_ENTRY = $clog2(NUM_ENTRY)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           I_Issue,
  input  issue_no_t      I_Issue_No,
  input  commit_lane_t   I_En_Lane,
  input  commit_lane_t   I_Commit_Lane,
  input  lane_issue_no_t I_Commit_No,
  output logic           O_Full,
  output logic           O_Empty,
  output logic           O_Commit,
  output issue_no_t      O_Commit_No,
  output logic           O_Error
);

  localparam logic [WIDTH_ENTRY:0] FULL_COUNT = NUM_ENTRY[WIDTH_ENTRY:0];

  commit_tab_v [NUM_ENTRY-1:0] tab_q, tab_d;
  logic [WIDTH_ENTRY-1:0]      wp_q, rp_q;
  logic [WIDTH_ENTRY:0]        count_q;
  logic [NUM_ENTRY-1:0]        hit [NUM_LANE];
  commit_lane_t                new_commit;
  logic                        issue_ok, retire, err_d;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_match
    commit_match #(.NUM_ENTRY(NUM_ENTRY)) u_match (
      .tab      (tab_q),
      .valid    (I_Commit_Lane[g]),
      .issue_no (I_Commit_No[g]),
      .hit      (hit[g])
    );
  end

  assign O_Full  = (count_q == FULL_COUNT);
  assign O_Empty = (count_q == '0);

  always_comb begin
    tab_d      = tab_q;
    err_d      = 1'b0;
    new_commit = '0;
    issue_ok   = I_Issue && !O_Full;
    retire     = is_complete(tab_q[rp_q]);

    for (int l = 0; l < NUM_LANE; l++) begin
      if (I_Commit_Lane[l]) begin
        if (|hit[l]) begin
          for (int e = 0; e < NUM_ENTRY; e++) begin
            if (hit[l][e]) begin
              if (tab_q[e].en_lane[l]) tab_d[e].en_commit[l] = 1'b1;
              else                     err_d = 1'b1;
            end
          end
        end else if (issue_ok && (I_Commit_No[l] == I_Issue_No)) begin
          // commit racing its own issue folds into the entry being written
          if (I_En_Lane[l]) new_commit[l] = 1'b1;
          else              err_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (I_Issue && O_Full) err_d = 1'b1;

    if (issue_ok) begin
      tab_d[wp_q].v         = 1'b1;
      tab_d[wp_q].issue_no  = I_Issue_No;
      tab_d[wp_q].en_lane   = I_En_Lane;
      tab_d[wp_q].en_commit = new_commit;
    end

    // retire and issue never target the same slot: issue needs count<N, retire count>0
    if (retire) tab_d[rp_q] = '0;

    for (int e = 0; e < NUM_ENTRY; e++) begin
      tab_d[e].commit = is_complete(tab_d[e]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tab_q       <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      O_Commit    <= 1'b0;
      O_Commit_No <= '0;
      O_Error     <= 1'b0;
    end else begin
      tab_q    <= tab_d;
      O_Commit <= retire;
      O_Error  <= O_Error | err_d;
      if (issue_ok) wp_q <= wp_q + 1'b1;
      if (retire) begin
        rp_q        <= rp_q + 1'b1;
        O_Commit_No <= tab_q[rp_q].issue_no;
      end
      case ({issue_ok, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
